// File: rtl/bus_pkg.sv
// Shared types for the daisy-chained register bus: field widths, the
// transaction record carried between cores, and the initiator state encoding.
package bus_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DATA_W = 16;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic [BUS_DATA_W-1:0] wdata;
        logic [BUS_DATA_W-1:0] rdata;
        logic                  rw;
        logic                  valid;
    } bus_xact_t;

    typedef enum logic [1:0] {
        INIT_IDLE,
        INIT_ISSUE,
        INIT_WAIT,
        INIT_RESP
    } init_state_e;

endpackage

// File: rtl/bus_watchdog.sv
// Cycle watchdog for the initiator's wait phase: counts enabled cycles since
// the last clear and flags expiry once TIMEOUT cycles have been spent waiting.
module bus_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count_q, count_d;

    assign expired_o = enable_i && (count_q == CNT_W'(TIMEOUT - 1));

    // Saturate at expiry so a lingering enable cannot wrap the count.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !expired_o) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bus_initiator.sv
// Head-of-chain bus initiator: turns a host request/response handshake into a
// single outstanding bus transaction. Define BUS_INITIATOR_TIMEOUT_EN for the watchdog.
module bus_initiator
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 64
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BUS_ADDR_W-1:0] req_addr_i,
    input  logic [BUS_DATA_W-1:0] req_wdata_i,
    input  logic                  req_rw_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    output logic [BUS_ADDR_W-1:0] addr_o,
    output logic [BUS_DATA_W-1:0] wdata_o,
    output logic [BUS_DATA_W-1:0] rdata_o,
    output logic                  rw_o,
    output logic                  valid_o,
    input  logic [BUS_ADDR_W-1:0] addr_i,
    input  logic [BUS_DATA_W-1:0] wdata_i,
    input  logic [BUS_DATA_W-1:0] rdata_i,
    input  logic                  rw_i,
    input  logic                  valid_i,
    output logic [BUS_DATA_W-1:0] resp_rdata_o,
    output logic                  resp_rw_o,
    output logic                  resp_err_o,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i
);

    init_state_e               state_q, state_d;
    bus_xact_t                 bus_q, bus_d;
    logic                      resp_valid_q, resp_valid_d;
    logic [BUS_DATA_W-1:0]     resp_rdata_q, resp_rdata_d;
    logic                      resp_rw_q, resp_rw_d;
    logic                      resp_err_q, resp_err_d;
    logic                      match;
    logic                      timeout_hit;
    logic                      unused_wdata;

    assign unused_wdata = ^wdata_i;

    assign match = valid_i && (addr_i == bus_q.addr) && (rw_i == bus_q.rw);

`ifdef BUS_INITIATOR_TIMEOUT_EN
    bus_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (state_q == INIT_ISSUE),
        .enable_i (state_q == INIT_WAIT),
        .expired_o(timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        bus_d        = bus_q;
        bus_d.valid  = 1'b0;
        bus_d.rdata  = '0;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_rw_d    = resp_rw_q;
        resp_err_d   = resp_err_q;
        unique case (state_q)
            INIT_IDLE: begin
                if (req_valid_i) begin
                    bus_d.addr  = req_addr_i;
                    bus_d.wdata = req_wdata_i;
                    bus_d.rw    = req_rw_i;
                    bus_d.valid = 1'b1;
                    state_d     = INIT_ISSUE;
                end
            end
            INIT_ISSUE: begin
                state_d = INIT_WAIT;
            end
            INIT_WAIT: begin
                // A real return beats a watchdog expiry landing in the same cycle.
                if (match) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = bus_q.rw ? '0 : rdata_i;
                    resp_rw_d    = bus_q.rw;
                    resp_err_d   = 1'b0;
                    state_d      = INIT_RESP;
                end else if (timeout_hit) begin
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    resp_rw_d    = bus_q.rw;
                    resp_err_d   = 1'b1;
                    state_d      = INIT_RESP;
                end
            end
            INIT_RESP: begin
                if (resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    state_d      = INIT_IDLE;
                end
            end
            default: begin
                state_d = INIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= INIT_IDLE;
            bus_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_rw_q    <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bus_q        <= bus_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_rw_q    <= resp_rw_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready_o  = (state_q == INIT_IDLE) && !rst;
    assign addr_o       = bus_q.addr;
    assign wdata_o      = bus_q.wdata;
    assign rdata_o      = bus_q.rdata;
    assign rw_o         = bus_q.rw;
    assign valid_o      = bus_q.valid;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_rw_o    = resp_rw_q;
    assign resp_err_o   = resp_err_q;
    assign resp_valid_o = resp_valid_q;

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: a K-stage loopback chain model plus directed and
// randomized transactions. Build with BUS_INITIATOR_TIMEOUT_EN to cover the watchdog.
module tb_bus_initiator;

    localparam int K   = 2;
    localparam int TMO = 8;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] rdata;
        logic        rw;
        logic        valid;
    } ret_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] req_addr, req_wdata;
    logic        req_rw, req_valid, req_ready_o;
    logic [15:0] addr_o, wdata_o, rdata_o;
    logic        rw_o, valid_o;
    logic [15:0] addr_i, wdata_i, rdata_i;
    logic        rw_i, valid_i;
    logic [15:0] resp_rdata_o;
    logic        resp_rw_o, resp_err_o, resp_valid_o;
    logic        resp_ready;

    logic        loopEn;
    logic [15:0] retData;
    logic [15:0] manAddr, manRdata, manWdata;
    logic        manRw, manValid;
    ret_t        chain [0:K-1];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_initiator #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .req_rw_i    (req_rw),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready_o),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .rdata_o     (rdata_o),
        .rw_o        (rw_o),
        .valid_o     (valid_o),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_i     (rdata_i),
        .rw_i        (rw_i),
        .valid_i     (valid_i),
        .resp_rdata_o(resp_rdata_o),
        .resp_rw_o   (resp_rw_o),
        .resp_err_o  (resp_err_o),
        .resp_valid_o(resp_valid_o),
        .resp_ready_i(resp_ready)
    );

    // Loopback chain of K registered cores; the addressed core supplies retData.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K; i++) chain[i] <= '0;
        end else begin
            chain[0] <= '{addr: addr_o, rdata: retData, rw: rw_o, valid: valid_o};
            for (int i = 1; i < K; i++) chain[i] <= chain[i-1];
        end
    end

    assign addr_i  = loopEn ? chain[K-1].addr  : manAddr;
    assign rdata_i = loopEn ? chain[K-1].rdata : manRdata;
    assign rw_i    = loopEn ? chain[K-1].rw    : manRw;
    assign valid_i = loopEn ? chain[K-1].valid : manValid;
    assign wdata_i = manWdata;

    // Offer a request at a negedge; returns one cycle later with the bus strobe checked.
    task automatic issue(input logic [15:0] a, input logic [15:0] w, input logic rw, input string tag);
        req_addr = a; req_wdata = w; req_rw = rw; req_valid = 1'b1;
        #1;
        total++;
        if (req_ready_o !== 1'b1) begin
            bad++; $display("[TB] FAIL %s_ready: got %b want 1", tag, req_ready_o);
        end
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if ({valid_o, addr_o, wdata_o, rw_o, rdata_o} !== {1'b1, a, w, rw, 16'h0}) begin
            bad++;
            $display("[TB] FAIL %s_bus: got v=%b a=%h w=%h rw=%b rd=%h want v=1 a=%h w=%h rw=%b rd=0000",
                     tag, valid_o, addr_o, wdata_o, rw_o, rdata_o, a, w, rw);
        end
    endtask

    task automatic await_resp(input int expC, input logic [15:0] expRd, input logic expRw,
                              input logic expErr, input string tag);
        int c = 1;
        while (resp_valid_o !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
            if (c == 2) begin
                total++;
                if (valid_o !== 1'b0) begin
                    bad++; $display("[TB] FAIL %s_strobe_len: got valid_o=%b want 0", tag, valid_o);
                end
            end
        end
        total++;
        if (c !== expC) begin
            bad++; $display("[TB] FAIL %s_latency: got %0d want %0d", tag, c, expC);
        end
        total++;
        if ({resp_valid_o, resp_rdata_o, resp_rw_o, resp_err_o} !== {1'b1, expRd, expRw, expErr}) begin
            bad++;
            $display("[TB] FAIL %s_resp: got v=%b rd=%h rw=%b err=%b want v=1 rd=%h rw=%b err=%b",
                     tag, resp_valid_o, resp_rdata_o, resp_rw_o, resp_err_o, expRd, expRw, expErr);
        end
    endtask

    task automatic finish_resp(input string tag);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        total++;
        if ({resp_valid_o, req_ready_o} !== 2'b01) begin
            bad++; $display("[TB] FAIL %s_handshake: got rv=%b rr=%b want rv=0 rr=1", tag, resp_valid_o, req_ready_o);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; loopEn = 1'b1; manValid = 1'b0;
        manAddr = '0; manRdata = '0; manRw = 1'b0; manWdata = 16'h5555; retData = '0;
        req_addr = '0; req_wdata = '0; req_rw = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({req_ready_o, valid_o, addr_o, wdata_o, rdata_o, rw_o} !== '0) begin
            bad++; $display("[TB] FAIL reset_bus: got rr=%b v=%b a=%h w=%h rd=%h rw=%b want all 0",
                            req_ready_o, valid_o, addr_o, wdata_o, rdata_o, rw_o);
        end
        total++;
        if ({resp_valid_o, resp_rdata_o, resp_rw_o, resp_err_o} !== '0) begin
            bad++; $display("[TB] FAIL reset_resp: got v=%b rd=%h rw=%b err=%b want all 0",
                            resp_valid_o, resp_rdata_o, resp_rw_o, resp_err_o);
        end
        rst = 1'b0;
        #1;
        total++;
        if (req_ready_o !== 1'b1) begin
            bad++; $display("[TB] FAIL reset_release_ready: got %b want 1", req_ready_o);
        end
        @(negedge clk);
    endtask

    task automatic test_read();
        loopEn = 1'b1; retData = 16'hBEEF;
        issue(16'h0003, 16'h0000, 1'b0, "read");
        await_resp(K + 2, 16'hBEEF, 1'b0, 1'b0, "read");
        finish_resp("read");
    endtask

    task automatic test_write();
        loopEn = 1'b1; retData = 16'hCAFE;
        issue(16'h0010, 16'h1234, 1'b1, "write");
        await_resp(K + 2, 16'h0000, 1'b1, 1'b0, "write");
        finish_resp("write");
    endtask

    task automatic test_drop();
        loopEn = 1'b0;
        issue(16'h0003, 16'h0000, 1'b0, "drop");
        @(negedge clk);
        manAddr = 16'h0004; manRw = 1'b0; manRdata = 16'hDEAD; manValid = 1'b1;
        @(negedge clk);
        manAddr = 16'h0003; manRw = 1'b1;
        total++;
        if (resp_valid_o !== 1'b0) begin
            bad++; $display("[TB] FAIL drop_wrong_addr: got resp_valid=%b want 0", resp_valid_o);
        end
        @(negedge clk);
        total++;
        if (resp_valid_o !== 1'b0) begin
            bad++; $display("[TB] FAIL drop_wrong_rw: got resp_valid=%b want 0", resp_valid_o);
        end
        manRw = 1'b0; manRdata = 16'h1111;
        @(negedge clk);
        manValid = 1'b0;
        total++;
        if ({resp_valid_o, resp_rdata_o, resp_err_o} !== {1'b1, 16'h1111, 1'b0}) begin
            bad++; $display("[TB] FAIL drop_match: got v=%b rd=%h err=%b want v=1 rd=1111 err=0",
                            resp_valid_o, resp_rdata_o, resp_err_o);
        end
        finish_resp("drop");
    endtask

    task automatic test_backpressure();
        loopEn = 1'b1; retData = 16'h5A5A;
        issue(16'h0020, 16'h0000, 1'b0, "bp");
        await_resp(K + 2, 16'h5A5A, 1'b0, 1'b0, "bp");
        req_addr = 16'h0030; req_wdata = 16'h7777; req_rw = 1'b1; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({resp_valid_o, resp_rdata_o, resp_rw_o, req_ready_o, valid_o} !== {1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0}) begin
                bad++; $display("[TB] FAIL bp_hold%0d: got rv=%b rd=%h rw=%b rr=%b v=%b want rv=1 rd=5a5a rw=0 rr=0 v=0",
                                i, resp_valid_o, resp_rdata_o, resp_rw_o, req_ready_o, valid_o);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        total++;
        if ({resp_valid_o, req_ready_o, valid_o} !== 3'b010) begin
            bad++; $display("[TB] FAIL bp_release: got rv=%b rr=%b v=%b want rv=0 rr=1 v=0",
                            resp_valid_o, req_ready_o, valid_o);
        end
        issue(16'h0030, 16'h7777, 1'b1, "bp_next");
        await_resp(K + 2, 16'h0000, 1'b1, 1'b0, "bp_next");
        finish_resp("bp_next");
    endtask

    task automatic test_reset_mid();
        loopEn = 1'b0;
        issue(16'h0003, 16'h0000, 1'b0, "rstmid");
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        manAddr = 16'h0003; manRw = 1'b0; manRdata = 16'hBEEF; manValid = 1'b1;
        @(negedge clk);
        manValid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({resp_valid_o, resp_rdata_o, resp_err_o, valid_o, addr_o, wdata_o, rw_o, req_ready_o} !==
            {1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1}) begin
            bad++; $display("[TB] FAIL rstmid_abandon: got rv=%b rd=%h err=%b v=%b a=%h w=%h rw=%b rr=%b want all 0 rr=1",
                            resp_valid_o, resp_rdata_o, resp_err_o, valid_o, addr_o, wdata_o, rw_o, req_ready_o);
        end
    endtask

`ifdef BUS_INITIATOR_TIMEOUT_EN
    task automatic test_timeout();
        loopEn = 1'b0;
        issue(16'h0040, 16'h0000, 1'b0, "tmo");
        await_resp(TMO + 2, 16'h0000, 1'b0, 1'b1, "tmo");
        finish_resp("tmo");
        issue(16'h0041, 16'h0000, 1'b0, "tmo_edge");
        repeat (TMO) @(negedge clk);
        manAddr = 16'h0041; manRw = 1'b0; manRdata = 16'h2222; manValid = 1'b1;
        @(negedge clk);
        manValid = 1'b0;
        total++;
        if ({resp_valid_o, resp_rdata_o, resp_err_o} !== {1'b1, 16'h2222, 1'b0}) begin
            bad++; $display("[TB] FAIL tmo_edge_match: got v=%b rd=%h err=%b want v=1 rd=2222 err=0",
                            resp_valid_o, resp_rdata_o, resp_err_o);
        end
        finish_resp("tmo_edge");
    endtask
`else
    task automatic test_no_timeout();
        loopEn = 1'b0;
        issue(16'h0040, 16'h0000, 1'b0, "notmo");
        repeat (80) @(negedge clk);
        total++;
        if ({resp_valid_o, resp_err_o} !== 2'b00) begin
            bad++; $display("[TB] FAIL notmo_wait: got v=%b err=%b want v=0 err=0", resp_valid_o, resp_err_o);
        end
        manAddr = 16'h0040; manRw = 1'b0; manRdata = 16'h3333; manValid = 1'b1;
        @(negedge clk);
        manValid = 1'b0;
        total++;
        if ({resp_valid_o, resp_rdata_o, resp_err_o} !== {1'b1, 16'h3333, 1'b0}) begin
            bad++; $display("[TB] FAIL notmo_match: got v=%b rd=%h err=%b want v=1 rd=3333 err=0",
                            resp_valid_o, resp_rdata_o, resp_err_o);
        end
        finish_resp("notmo");
    endtask
`endif

    task automatic test_random();
        logic [15:0] a, w, d;
        logic        rw;
        int          hold;
        loopEn = 1'b1;
        for (int n = 0; n < 25; n++) begin
            a  = 16'($urandom);
            w  = 16'($urandom);
            d  = 16'($urandom);
            rw = 1'($urandom_range(0, 1));
            retData  = d;
            manWdata = 16'($urandom);
            issue(a, w, rw, "rand");
            await_resp(K + 2, rw ? 16'h0000 : d, rw, 1'b0, "rand");
            hold = $urandom_range(0, 3);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                total++;
                if ({resp_valid_o, resp_rdata_o, resp_rw_o} !== {1'b1, (rw ? 16'h0000 : d), rw}) begin
                    bad++; $display("[TB] FAIL rand_hold: got v=%b rd=%h rw=%b want v=1 rd=%h rw=%b",
                                    resp_valid_o, resp_rdata_o, resp_rw_o, rw ? 16'h0000 : d, rw);
                end
            end
            finish_resp("rand");
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_drop();
        test_backpressure();
        test_reset_mid();
`ifdef BUS_INITIATOR_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("[TB] FAIL global_time_limit: got still running want finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
